// File: rtl/uart_rx_par_chk.sv
// -----------------------------------------------------------------------------
// uart_rx_par_chk
//
// Parity checker for the UART receive datapath. On the RX FSM's single-cycle
// check strobe, it compares the sampled parity bit with the parity expected for
// the deserialized data word. The result is registered in par_err. A saturating
// counter keeps a running total of parity errors for status readback.
//
// Ports:
//   clk          in   receiver clock; all state changes on the rising edge
//   rst          in   asynchronous active-low reset
//   par_chk_en   in   check strobe; every high cycle is one independent check
//   sampled_bit  in   parity bit as sampled from the line
//   p_data       in   deserialized data word (DATA_WIDTH bits)
//   par_typ      in   0 = even parity, 1 = odd parity
//   par_err      out  registered parity-error flag
//   par_err_cnt  out  saturating parity-error count (CNT_WIDTH bits)
//
// Handshake: par_chk_en is a qualifier-only strobe with no ready/busy side.
// Data, parity type and sampled bit are sampled only on an edge where
// par_chk_en is 1, and are don't-care on every other cycle. The block has no
// FSM, so there is no state to expose beyond the two outputs.
// -----------------------------------------------------------------------------
module uart_rx_par_chk #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  par_chk_en,
  input  logic                  sampled_bit,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  par_typ,
  output logic                  par_err,
  output logic [CNT_WIDTH-1:0]  par_err_cnt
);

  logic exp_par;
  logic mis;
  logic cnt_sat;

  // For odd parity, flipping the even-parity bit gives the expected bit,
  // so par_typ is simply XORed into the reduction.
  assign exp_par = (^p_data) ^ par_typ;
  assign mis     = sampled_bit ^ exp_par;
  assign cnt_sat = &par_err_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_err     <= 1'b0;
      par_err_cnt <= '0;
    end else if (par_chk_en) begin
      par_err <= mis;
      // Hold at all-ones rather than wrap, so software never sees a small
      // count after a burst of errors.
      if (mis && !cnt_sat) begin
        par_err_cnt <= par_err_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_par_chk.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_par_chk
//
// Bench for uart_rx_par_chk. The reference model computes the expected parity
// by counting ones in the data word. The expected error count is kept as a
// plain integer clamped at its maximum. Each expected {par_err, par_err_cnt}
// pair is queued, then popped after the clock edge it belongs to.
// -----------------------------------------------------------------------------
module tb_uart_rx_par_chk;

  localparam int DW      = 8;
  localparam int CW      = 8;
  localparam int CNT_MAX = (1 << CW) - 1;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst;
  logic          par_chk_en;
  logic          sampled_bit;
  logic [DW-1:0] p_data;
  logic          par_typ;
  logic          par_err;
  logic [CW-1:0] par_err_cnt;

  always #5 clk = ~clk;

  uart_rx_par_chk #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .par_chk_en  (par_chk_en),
    .sampled_bit (sampled_bit),
    .p_data      (p_data),
    .par_typ     (par_typ),
    .par_err     (par_err),
    .par_err_cnt (par_err_cnt)
  );

  // ---------------- scoreboard ----------------
  logic [CW:0] exp_q[$];
  int          n_checks = 0;
  int          n_errs   = 0;
  int          m_err    = 0;
  int          m_cnt    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the parity bit that makes the total number of ones even
  // (par_typ=0) or odd (par_typ=1).
  function automatic int ref_parity(input logic [DW-1:0] d, input logic t);
    int ones;
    ones = 0;
    for (int i = 0; i < DW; i++) ones += int'(d[i]);
    return t ? ((ones + 1) % 2) : (ones % 2);
  endfunction

  task automatic push_expected();
    exp_q.push_back({m_err[0], m_cnt[CW-1:0]});
  endtask

  task automatic compare_outputs(input string tag);
    logic [CW:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_qempty"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_err"}, 32'(par_err), 32'(e[CW]));
      chk({tag, "_cnt"}, 32'(par_err_cnt), 32'(e[CW-1:0]));
    end
  endtask

  // ---------------- driver tasks ----------------
  // One strobe cycle. Consecutive calls produce back-to-back strobes.
  task automatic strobe(input logic [DW-1:0] d, input logic t, input logic s, input string tag);
    @(negedge clk);
    p_data      = d;
    par_typ     = t;
    sampled_bit = s;
    par_chk_en  = 1'b1;
    @(posedge clk);
    if (rst) begin
      m_err = (int'(s) != ref_parity(d, t)) ? 1 : 0;
      if (m_err == 1 && m_cnt < CNT_MAX) m_cnt++;
    end
    push_expected();
    #1;
    compare_outputs(tag);
  endtask

  // Idle cycles with garbage on the don't-care inputs. Outputs must hold.
  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      par_chk_en  = 1'b0;
      p_data      = DW'($urandom);
      par_typ     = 1'($urandom);
      sampled_bit = 1'($urandom);
      @(posedge clk);
      push_expected();
      #1;
      compare_outputs(tag);
    end
  endtask

  // Strobe whose sampled bit disagrees with the reference parity.
  task automatic strobe_bad(input string tag);
    logic [DW-1:0] d;
    logic          t;
    d = DW'($urandom);
    t = 1'($urandom);
    strobe(d, t, ref_parity(d, t) == 0, tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst         = 1'b0;
    par_chk_en  = 1'b0;
    sampled_bit = 1'b0;
    p_data      = '0;
    par_typ     = 1'b0;

    // Reset held: strobes with mismatching data must not disturb the outputs.
    #1;
    chk("rst_async_err", 32'(par_err), 32'd0);
    chk("rst_async_cnt", 32'(par_err_cnt), 32'd0);
    for (int i = 0; i < 4; i++) strobe(8'hF0, 1'b0, 1'b1, "rst_hold");

    @(negedge clk);
    par_chk_en = 1'b0;
    rst        = 1'b1;
    idle(3, "post_rst");

    // Even-parity error, then hold after the strobe drops.
    strobe(8'hF0, 1'b0, 1'b1, "even_err");
    idle(2, "even_err_hold");

    // Even and odd parity passes.
    strobe(8'hF0, 1'b0, 1'b0, "even_pass");
    strobe(8'h01, 1'b1, 1'b0, "odd_pass");

    // Odd-parity error, then recovery on the next strobe.
    strobe(8'h07, 1'b1, 1'b1, "odd_err");
    strobe(8'h07, 1'b1, 1'b0, "odd_recover");

    // No strobe for 10 cycles while the inputs disagree.
    strobe(8'h03, 1'b0, 1'b1, "pre_idle_err");
    idle(10, "no_strobe");

    // Random mix of strobes and gaps.
    for (int i = 0; i < 200; i++) begin
      strobe(DW'($urandom), 1'($urandom), 1'($urandom), "rand");
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3), "rand_gap");
    end

    // Saturation from a clean count: 260 back-to-back mismatching strobes.
    @(negedge clk);
    par_chk_en = 1'b0;
    rst        = 1'b0;
    m_err      = 0;
    m_cnt      = 0;
    #1;
    chk("sat_pre_rst_err", 32'(par_err), 32'd0);
    chk("sat_pre_rst_cnt", 32'(par_err_cnt), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 260; i++) strobe_bad("sat");
    chk("sat_cnt_max", 32'(par_err_cnt), 32'(CNT_MAX));
    chk("sat_err_flag", 32'(par_err), 32'd1);

    // Reset while the strobe is still high: the outputs clear with no clock edge.
    #2;
    rst = 1'b0;
    m_err = 0;
    m_cnt = 0;
    #1;
    chk("midstrobe_rst_err", 32'(par_err), 32'd0);
    chk("midstrobe_rst_cnt", 32'(par_err_cnt), 32'd0);
    // Reset wins over a strobe at the same edge.
    strobe(8'hFF, 1'b1, 1'b0, "rst_vs_strobe");

    @(negedge clk);
    par_chk_en = 1'b0;
    rst        = 1'b1;
    strobe(8'h01, 1'b0, 1'b0, "after_rel_err");
    idle(1, "final_hold");

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within bound");
    n_errs++;
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
